// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM column access controller.
// Optional perf counters are enabled with SRAM_CTRL_PERF_CNT_EN.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PRE     = 3'd1,
    ST_SETUP   = 3'd2,
    ST_ACCESS  = 3'd3,
    ST_SENSE   = 3'd4,
    ST_RECOVER = 3'd5
  } ctrl_state_e;

  localparam int DEF_PRE_CYC   = 2;
  localparam int DEF_WL_CYC    = 2;
  localparam int DEF_SENSE_CYC = 1;
  localparam int PERF_CNT_W    = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sram_col_onehot_dec.sv
// Binary column index to one-hot column-mux select, forced to zero when disabled.
module sram_col_onehot_dec #(
  parameter int COL_W = 3
) (
  input  logic                  en,
  input  logic [COL_W-1:0]      col,
  output logic [2**COL_W-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[col] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_col_access_ctrl.sv
// Single-request access sequencer for the column transmission-gate muxes.
// Build option: define SRAM_CTRL_PERF_CNT_EN to add saturating rd_cnt/wr_cnt outputs.
module sram_col_access_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ROW_W     = 8,
  parameter int COL_W     = 3,
  parameter int DATA_W    = 8,
  parameter int PRE_CYC   = DEF_PRE_CYC,
  parameter int WL_CYC    = DEF_WL_CYC,
  parameter int SENSE_CYC = DEF_SENSE_CYC
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ROW_W+COL_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]       req_wdata,
  output logic [ROW_W-1:0]        row_addr,
  output logic                    wl_en,
  output logic                    precharge_n,
  output logic                    write_en,
  output logic [2**COL_W-1:0]     col_sel,
  output logic                    sense_en,
  output logic [DATA_W-1:0]       wdata_drv,
  output logic                    wdata_oe,
  input  logic [DATA_W-1:0]       sa_rdata,
  output logic                    rd_valid,
  output logic [DATA_W-1:0]       rd_data
`ifdef SRAM_CTRL_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0]   rd_cnt,
  output logic [PERF_CNT_W-1:0]   wr_cnt
`endif
);

  localparam int TMR_W = $clog2(max3(PRE_CYC, WL_CYC, SENSE_CYC) + 1);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // the requester must hold req_valid and its payload stable until then.

  ctrl_state_e       state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              we_q;
  logic [ROW_W-1:0]  row_q;
  logic [COL_W-1:0]  col_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              accept;
  logic              capture;
  logic              col_en;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          tmr_d   = TMR_W'(PRE_CYC);
          state_d = ST_PRE;
        end
      end
      ST_PRE: begin
        if (tmr_q == TMR_W'(1)) begin
          state_d = ST_SETUP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SETUP: begin
        tmr_d   = TMR_W'(WL_CYC);
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (tmr_q == TMR_W'(1)) begin
          if (we_q) begin
            state_d = ST_RECOVER;
          end else begin
            tmr_d   = TMR_W'(SENSE_CYC);
            state_d = ST_SENSE;
          end
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_SENSE: begin
        if (tmr_q == TMR_W'(1)) begin
          capture = 1'b1;
          state_d = ST_RECOVER;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_RECOVER: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      we_q      <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      if (accept) begin
        we_q    <= req_we;
        row_q   <= req_addr[ROW_W+COL_W-1:COL_W];
        col_q   <= req_addr[COL_W-1:0];
        wdata_q <= req_wdata;
      end
      if (capture) begin
        rd_data_q <= sa_rdata;
      end
    end
  end

  // Outputs decode straight from the state register so an async reset clears them at once.
  // write_en is held for the whole access and only drops in IDLE, where col_sel is already 0.
  always_comb begin
    req_ready   = 1'b0;
    precharge_n = 1'b1;
    wl_en       = 1'b0;
    write_en    = 1'b0;
    col_en      = 1'b0;
    sense_en    = 1'b0;
    wdata_oe    = 1'b0;
    rd_valid    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready   = 1'b1;
        precharge_n = 1'b0;
      end
      ST_PRE: begin
        precharge_n = 1'b0;
        write_en    = we_q;
      end
      ST_SETUP, ST_ACCESS: begin
        write_en = we_q;
        wl_en    = 1'b1;
        col_en   = 1'b1;
        wdata_oe = we_q;
      end
      ST_SENSE: begin
        write_en = we_q;
        wl_en    = 1'b1;
        col_en   = 1'b1;
        sense_en = !we_q;
      end
      ST_RECOVER: begin
        write_en = we_q;
        rd_valid = !we_q;
      end
      default: begin
        req_ready = 1'b0;
      end
    endcase
  end

  assign wdata_drv = wdata_oe ? wdata_q : '0;
  assign row_addr  = row_q;
  assign rd_data   = rd_data_q;

  sram_col_onehot_dec #(
    .COL_W (COL_W)
  ) u_col_dec (
    .en     (col_en),
    .col    (col_q),
    .onehot (col_sel)
  );

`ifdef SRAM_CTRL_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] rd_cnt_q;
  logic [PERF_CNT_W-1:0] wr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (accept) begin
      if (!req_we && (rd_cnt_q != '1)) begin
        rd_cnt_q <= rd_cnt_q + PERF_CNT_W'(1);
      end
      if (req_we && (wr_cnt_q != '1)) begin
        wr_cnt_q <= wr_cnt_q + PERF_CNT_W'(1);
      end
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule
